hdmi_pattern_sched: RTL and testbench

- Frame-synchronous test-pattern scheduler and generator for the 720p DVI/HDMI test path.
- Sits between rgb_timing and DVI_TX_Top in the pixel clock domain.
- Selects one of four patterns by automatic rotation or host request; pattern changes take effect only at frame boundaries.
- Outputs RGB565 plus hs/vs/de, all delayed to stay aligned with the pixel data.

---
 rtl/hdmi_pattern_sched.sv | 176 +++++++++++++++++
 tb/tb_hdmi_pattern_sched.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_pattern_sched.sv
// hdmi_pattern_sched: frame-synchronous test-pattern scheduler and RGB565 generator.
// Four patterns (bit-walk, colour bars, grid, grey ramp) rotate automatically every
// FRAMES_PER_PAT frames or are chosen by a host request. Pattern changes land only on
// the frame boundary so a frame is never torn. Pixel and timing outputs have 1-cycle latency.
// Optional: define PAT_SCHED_FRAMECNT_EN to add a free-running 16-bit frame counter output.
module hdmi_pattern_sched #(
    parameter int H_ACTIVE       = 1280,
    parameter int V_ACTIVE       = 720,
    parameter int FRAMES_PER_PAT = 60,
    parameter bit VS_POL         = 1'b1,
    parameter int GRID_SHIFT     = 5
) (
    input  logic        rgb_clk,
    input  logic        rgb_rst_n,
    input  logic [10:0] rgb_x,
    input  logic [10:0] rgb_y,
    input  logic        rgb_hs,
    input  logic        rgb_vs,
    input  logic        rgb_de,
    input  logic        auto_en,
    input  logic        req_valid,
    input  logic [1:0]  req_id,
    output logic        req_ready,
    output logic [1:0]  pat_id,
    output logic        pat_manual,
    output logic        out_hs,
    output logic        out_vs,
    output logic        out_de,
    output logic [4:0]  out_r,
    output logic [5:0]  out_g,
    output logic [4:0]  out_b
`ifdef PAT_SCHED_FRAMECNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    localparam int BAR16_W = H_ACTIVE / 16;
    localparam int BAR8_W  = H_ACTIVE / 8;
    localparam int CNT_W   = (FRAMES_PER_PAT > 1) ? $clog2(FRAMES_PER_PAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_PAT - 1);

    typedef enum logic [0:0] {StAuto, StManual} mode_e;

    mode_e             mode_q, mode_d;
    logic [1:0]        pat_q, pat_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pend_q, pend_d;
    logic [1:0]        pend_id_q, pend_id_d;
    logic              vs_d_q;
    logic              fb;
    logic              accept;

    assign req_ready  = rgb_rst_n & ~pend_q;
    assign accept     = req_valid & req_ready;
    assign fb         = (rgb_vs == VS_POL) && (vs_d_q != VS_POL);
    assign pat_id     = pat_q;
    assign pat_manual = (mode_q == StManual);

    // Scheduler state register.
    always_ff @(posedge rgb_clk) begin
        if (!rgb_rst_n) begin
            mode_q    <= StAuto;
            pat_q     <= 2'd0;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            pend_id_q <= 2'd0;
            vs_d_q    <= ~VS_POL;
        end else begin
            mode_q    <= mode_d;
            pat_q     <= pat_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            pend_id_q <= pend_id_d;
            vs_d_q    <= rgb_vs;
        end
    end

    // Next-state: request capture, then frame-boundary priority pending > auto_en > counting.
    always_comb begin
        mode_d    = mode_q;
        pat_d     = pat_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        pend_id_d = pend_id_q;
        // accept implies pend_q==0, so it never collides with the pending apply below
        if (accept) begin
            pend_d    = 1'b1;
            pend_id_d = req_id;
        end
        if (fb) begin
            if (pend_q) begin
                pat_d  = pend_id_q;
                mode_d = StManual;
                pend_d = 1'b0;
                cnt_d  = '0;
            end else if (auto_en && (mode_q == StManual)) begin
                mode_d = StAuto;
                cnt_d  = '0;
            end else if (mode_q == StAuto) begin
                if (cnt_q == CNT_LAST) begin
                    pat_d = pat_q + 2'd1;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

`ifdef PAT_SCHED_FRAMECNT_EN
    logic [15:0] frame_cnt_q;
    assign frame_cnt = frame_cnt_q;

    // Free-running frame counter, wraps naturally at 16 bits.
    always_ff @(posedge rgb_clk) begin
        if (!rgb_rst_n) begin
            frame_cnt_q <= 16'd0;
        end else if (fb) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end
`endif

    logic [3:0]  bar16;
    logic [2:0]  bar8;
    logic [15:0] pix;

    // Pattern generator: bar index by constant compares; x past the active width clamps to last bar.
    always_comb begin
        bar16 = 4'd0;
        bar8  = 3'd0;
        pix   = 16'd0;
        for (int i = 1; i < 16; i++) begin
            if (32'(rgb_x) >= i * BAR16_W) bar16 = 4'(i);
        end
        for (int i = 1; i < 8; i++) begin
            if (32'(rgb_x) >= i * BAR8_W) bar8 = 3'(i);
        end
        case (pat_q)
            2'd0: pix = 16'h8000 >> bar16;
            // white, yellow, cyan, green, magenta, red, blue, black
            2'd1: pix = {{5{~bar8[1]}}, {6{~bar8[2]}}, {5{~bar8[0]}}};
            2'd2: begin
                if ((rgb_x[GRID_SHIFT-1:0] == '0) ||
                    ((rgb_y[GRID_SHIFT-1:0] == '0) && (32'(rgb_y) < V_ACTIVE))) begin
                    pix = 16'hffff;
                end
            end
            default: pix = {rgb_x[10:6], rgb_x[10:5], rgb_x[10:6]};
        endcase
        if (!rgb_de) pix = 16'd0;
    end

    // Output pipeline register keeps timing aligned with pixel data.
    always_ff @(posedge rgb_clk) begin
        if (!rgb_rst_n) begin
            out_hs <= 1'b0;
            out_vs <= 1'b0;
            out_de <= 1'b0;
            out_r  <= 5'd0;
            out_g  <= 6'd0;
            out_b  <= 5'd0;
        end else begin
            out_hs <= rgb_hs;
            out_vs <= rgb_vs;
            out_de <= rgb_de;
            out_r  <= pix[15:11];
            out_g  <= pix[10:5];
            out_b  <= pix[4:0];
        end
    end

endmodule

// File: tb/tb_hdmi_pattern_sched.sv
// Directed bench for hdmi_pattern_sched with FRAMES_PER_PAT=2.
module tb_hdmi_pattern_sched;

    localparam int FPP = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] rgb_x, rgb_y;
    logic        rgb_hs, rgb_vs, rgb_de;
    logic        auto_en, req_valid;
    logic [1:0]  req_id;
    logic        req_ready;
    logic [1:0]  pat_id;
    logic        pat_manual;
    logic        out_hs, out_vs, out_de;
    logic [4:0]  out_r;
    logic [5:0]  out_g;
    logic [4:0]  out_b;
`ifdef PAT_SCHED_FRAMECNT_EN
    logic [15:0] frame_cnt;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hdmi_pattern_sched #(
        .H_ACTIVE       (1280),
        .V_ACTIVE       (720),
        .FRAMES_PER_PAT (FPP),
        .VS_POL         (1'b1),
        .GRID_SHIFT     (5)
    ) dut (
        .rgb_clk    (clk),
        .rgb_rst_n  (rst_n),
        .rgb_x      (rgb_x),
        .rgb_y      (rgb_y),
        .rgb_hs     (rgb_hs),
        .rgb_vs     (rgb_vs),
        .rgb_de     (rgb_de),
        .auto_en    (auto_en),
        .req_valid  (req_valid),
        .req_id     (req_id),
        .req_ready  (req_ready),
        .pat_id     (pat_id),
        .pat_manual (pat_manual),
        .out_hs     (out_hs),
        .out_vs     (out_vs),
        .out_de     (out_de),
        .out_r      (out_r),
        .out_g      (out_g),
        .out_b      (out_b)
`ifdef PAT_SCHED_FRAMECNT_EN
        ,
        .frame_cnt  (frame_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample point is 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic vs_pulse();
        rgb_vs = 1'b1;
        tick();
        rgb_vs = 1'b0;
        tick();
    endtask

    task automatic set_pat(input logic [1:0] id);
        req_valid = 1'b1;
        req_id    = id;
        tick();
        req_valid = 1'b0;
        tick();
        vs_pulse();
    endtask

    task automatic pixel(input int x, input int y, input logic de);
        rgb_x  = 11'(x);
        rgb_y  = 11'(y);
        rgb_de = de;
        tick();
    endtask

    task automatic chk_rgb(input string tag, input int r, input int g, input int b);
        chk({tag, ".r"}, 32'(out_r), r);
        chk({tag, ".g"}, 32'(out_g), g);
        chk({tag, ".b"}, 32'(out_b), b);
    endtask

    initial begin
        rst_n = 1'b0; rgb_x = '0; rgb_y = '0; rgb_hs = 1'b0; rgb_vs = 1'b0; rgb_de = 1'b0;
        auto_en = 1'b0; req_valid = 1'b0; req_id = 2'd0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        chk("rst.pat_id", 32'(pat_id), 0);
        chk("rst.manual", 32'(pat_manual), 0);
        chk("rst.ready", 32'(req_ready), 1);
        chk("rst.out_de", 32'(out_de), 0);
        chk_rgb("rst", 0, 0, 0);
`ifdef PAT_SCHED_FRAMECNT_EN
        chk("rst.frame_cnt", 32'(frame_cnt), 0);
`endif

        // AUTO rotation: 0,0,1,1,2,2 over five boundaries
        vs_pulse(); chk("auto.fb1", 32'(pat_id), 0);
`ifdef PAT_SCHED_FRAMECNT_EN
        chk("auto.frame_cnt", 32'(frame_cnt), 1);
`endif
        vs_pulse(); chk("auto.fb2", 32'(pat_id), 1);
        vs_pulse(); chk("auto.fb3", 32'(pat_id), 1);
        vs_pulse(); chk("auto.fb4", 32'(pat_id), 2);
        vs_pulse(); chk("auto.fb5", 32'(pat_id), 2);
        chk("auto.manual", 32'(pat_manual), 0);
        chk("auto.ready", 32'(req_ready), 1);

        // Manual request mid-frame
        req_valid = 1'b1; req_id = 2'd3;
        tick();
        req_valid = 1'b0;
        chk("req.ready_low", 32'(req_ready), 0);
        tick();
        chk("req.pat_before_fb", 32'(pat_id), 2);
        rgb_vs = 1'b1;
        tick();
        chk("req.pat_at_fb", 32'(pat_id), 3);
        chk("req.manual", 32'(pat_manual), 1);
        chk("req.ready_again", 32'(req_ready), 1);
        rgb_vs = 1'b0;
        tick();

        // Request accepted on the fb cycle itself
        rgb_vs = 1'b1; req_valid = 1'b1; req_id = 2'd1;
        tick();
        req_valid = 1'b0; rgb_vs = 1'b0;
        chk("fbreq.pat_unchanged", 32'(pat_id), 3);
        chk("fbreq.ready_low", 32'(req_ready), 0);
        tick();
        vs_pulse();
        chk("fbreq.pat_next_fb", 32'(pat_id), 1);

        // Pattern 1 colour bars
        rgb_hs = 1'b1;
        pixel(0, 5, 1'b1);    chk_rgb("bars.x0", 31, 63, 31);
        chk("bars.out_hs", 32'(out_hs), 1);
        chk("bars.out_de", 32'(out_de), 1);
        rgb_hs = 1'b0;
        pixel(160, 5, 1'b1);  chk_rgb("bars.x160", 31, 63, 0);
        pixel(800, 5, 1'b1);  chk_rgb("bars.x800", 31, 0, 0);
        pixel(1279, 5, 1'b1); chk_rgb("bars.x1279", 0, 0, 0);
        pixel(1500, 5, 1'b1); chk_rgb("bars.clamp", 0, 0, 0);
        pixel(0, 5, 1'b0);    chk_rgb("bars.de0", 0, 0, 0);
        chk("bars.out_de0", 32'(out_de), 0);

        // Pattern 0 bit-walk
        set_pat(2'd0);
        pixel(0, 0, 1'b1);    chk_rgb("walk.bar0", 16, 0, 0);
        pixel(400, 0, 1'b1);  chk_rgb("walk.bar5", 0, 32, 0);
        pixel(1200, 0, 1'b1); chk_rgb("walk.bar15", 0, 0, 1);

        // Pattern 3 grey ramp
        set_pat(2'd3);
        pixel(1279, 0, 1'b1); chk_rgb("grey.x1279", 19, 39, 19);

        // Pattern 2 grid, then auto_en back to AUTO
        set_pat(2'd2);
        pixel(32, 3, 1'b1);   chk_rgb("grid.vline", 31, 63, 31);
        pixel(33, 3, 1'b1);   chk_rgb("grid.blank", 0, 0, 0);
        pixel(33, 64, 1'b1);  chk_rgb("grid.hline", 31, 63, 31);
        rgb_de = 1'b0;
        auto_en = 1'b1;
        vs_pulse();
        auto_en = 1'b0;
        chk("ae.manual", 32'(pat_manual), 0);
        chk("ae.pat_hold0", 32'(pat_id), 2);
        vs_pulse(); chk("ae.pat_hold1", 32'(pat_id), 2);
        vs_pulse(); chk("ae.pat_adv", 32'(pat_id), 3);

        // Pending request and auto_en at the same boundary: request wins
        set_pat(2'd0);
        req_valid = 1'b1; req_id = 2'd1;
        tick();
        req_valid = 1'b0;
        auto_en = 1'b1;
        vs_pulse();
        auto_en = 1'b0;
        chk("prio.pat", 32'(pat_id), 1);
        chk("prio.manual", 32'(pat_manual), 1);

        // Reset mid-frame with pat_id=2 and a request pending
        set_pat(2'd2);
        req_valid = 1'b1; req_id = 2'd1;
        tick();
        req_valid = 1'b0;
        chk("mrst.pending", 32'(req_ready), 0);
        pixel(32, 0, 1'b1);
        chk_rgb("mrst.pre", 31, 63, 31);
        rst_n = 1'b0;
        tick();
        chk("mrst.pat", 32'(pat_id), 0);
        chk("mrst.manual", 32'(pat_manual), 0);
        chk("mrst.out_de", 32'(out_de), 0);
        chk_rgb("mrst.out", 0, 0, 0);
`ifdef PAT_SCHED_FRAMECNT_EN
        chk("mrst.frame_cnt", 32'(frame_cnt), 0);
`endif
        rst_n = 1'b1;
        rgb_de = 1'b0;
        #1;
        chk("mrst.ready", 32'(req_ready), 1);
        vs_pulse();
        chk("mrst.no_pending_pat", 32'(pat_id), 0);
        chk("mrst.no_pending_manual", 32'(pat_manual), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
